bcd_seq_conv: RTL and testbench
===============================

BCD_SEQ_CONV -- requirements
Module: bcd_seq_conv

Interface
REQ-001 SHALL have parameter WIDTH, default 8: binary input width, range 4..32.
REQ-002 SHALL have parameter DIGITS, default 3: BCD output digit count, range 1..10.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  in_data is valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an input.
REQ-007 SHALL have port in_data  input  WIDTH  binary operand.
REQ-008 SHALL have port out_valid  output  1  result is valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port out_bcd  output  4*DIGITS  packed BCD, digit 0 in bits [3:0].
REQ-011 SHALL have port out_sign  output  1  result sign, 1 = negative.
REQ-012 SHALL have port out_ovf  output  1  magnitude did not fit in DIGITS digits.
REQ-013 SHALL have port busy  output  1  conversion in progress.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE, busy=1 only in SHIFT, and out_valid=1 only in DONE.
REQ-016 On an input handshake (in_valid & in_ready), SHALL load the operand magnitude into a WIDTH-bit shift register, clear the BCD digit register and overflow flag, zero a step counter, and enter SHIFT.
REQ-017 In SHIFT, each cycle SHALL first add 3 to every BCD digit greater than 4, then shift {digits, operand} left by one bit, with the operand MSB entering digit 0 bit 0.
REQ-018 SHALL OR any bit shifted out of the top digit into the sticky overflow flag.
REQ-019 SHALL leave SHIFT for DONE on the edge that completes step WIDTH; out_valid SHALL rise exactly WIDTH edges after the accepting edge.
REQ-020 In DONE, SHALL hold out_bcd, out_sign and out_ovf stable until an output handshake (out_valid & out_ready), then return to IDLE.
REQ-021 A new input SHALL NOT be accepted in the cycle of the output handshake; the earliest next acceptance is one cycle later.
REQ-022 If overflow occurs, out_bcd SHALL equal the magnitude mod 10^DIGITS and out_ovf SHALL be 1; otherwise out_ovf SHALL be 0.
REQ-023 SHALL ignore in_valid outside IDLE, and in_data changes after acceptance SHALL NOT affect the result.
REQ-024 SHALL hold out_bcd, out_sign and out_ovf at 0 outside DONE.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE, clear all registers, and zero out_valid, out_bcd, out_sign, out_ovf and busy, in any state.
REQ-026 Reset during SHIFT or DONE SHALL abandon the conversion with no output handshake; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-027 rst SHALL take priority over simultaneous in_valid or out_ready.

Configuration
REQ-028 With macro BCD_SIGNED_EN defined, in_data SHALL be two's complement; at acceptance the magnitude SHALL be |in_data| as a WIDTH-bit unsigned value, with out_sign=1 when in_data MSB=1 (the most negative value gives magnitude 2^(WIDTH-1)).
REQ-029 Without BCD_SIGNED_EN, in_data SHALL be unsigned, out_sign SHALL be constant 0, and no negation logic SHALL be present.

Verification
REQ-030 WIDTH=8, DIGITS=3, unsigned: in_data=255 -> out_bcd=0x255, out_ovf=0, out_valid exactly 8 edges after acceptance; in_data=0 -> 0x000.
REQ-031 WIDTH=8, DIGITS=3: out_ready held low 5 cycles after out_valid -> outputs stable, in_ready=0 throughout, in_valid pulses ignored; IDLE follows the handshake.
REQ-032 WIDTH=8, DIGITS=2: in_data=200 -> out_bcd=0x00, out_ovf=1; in_data=99 -> 0x99, out_ovf=0.
REQ-033 WIDTH=16, DIGITS=5: in_data=65535 -> out_bcd=0x65535 after 16 edges; sweep 0..65535 against a reference model.
REQ-034 BCD_SIGNED_EN, WIDTH=8, DIGITS=3: in_data=0x80 -> out_sign=1, out_bcd=0x128; 0xFF -> sign 1, 0x001; 0x7F -> sign 0, 0x127.
REQ-035 rst pulsed at step 4 of SHIFT -> next cycle: IDLE, all outputs 0, in_ready=1; next conversion of 42 -> 0x042 correct.

Source files
------------

// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Optional feature: define BCD_SIGNED_EN for two's-complement operands with a sign output.
module bcd_seq_conv #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_sign,
    output logic                out_ovf,
    output logic                busy
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [BW-1:0]     bcd_adj;
    logic              ovf_q, ovf_d;
    logic              sign_q, sign_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  load_mag;
    logic              load_neg;

`ifdef BCD_SIGNED_EN
    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
    assign load_neg = in_data[WIDTH-1];
    assign load_mag = load_neg ? (~in_data) + WIDTH'(1) : in_data;
`else
    assign load_neg = 1'b0;
    assign load_mag = in_data;
`endif

    // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] > 4'd4) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        sign_d  = sign_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = load_mag;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    sign_d  = load_neg;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Bits leaving the top digit are multiples of 10^DIGITS: drop them, remember them.
                bcd_d   = {bcd_adj[BW-2:0], shift_q[WIDTH-1]};
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                ovf_d   = ovf_q | bcd_adj[BW-1];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous and clears every register; rst wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            sign_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            sign_q  <= sign_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign out_valid = (state_q == DONE);
    assign out_bcd   = out_valid ? bcd_q : '0;
    assign out_sign  = out_valid & sign_q;
    assign out_ovf   = out_valid & ovf_q;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Scoreboard bench for bcd_seq_conv: three instances (8/3, 8/2, 16/5), directed vectors plus a
// sparse 16-bit sweep against a divide-by-ten model; honours BCD_SIGNED_EN when defined.
module tb_bcd_seq_conv;

    typedef struct {
        logic [19:0] bcd;
        logic        sign;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: WIDTH=8, DIGITS=3, with a stalling consumer.
    logic a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic a_out_sign, a_out_ovf, a_busy;
    logic [7:0]  a_in_data = '0;
    logic [11:0] a_out_bcd;

    bcd_seq_conv #(.WIDTH(8), .DIGITS(3)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_bcd(a_out_bcd),
        .out_sign(a_out_sign), .out_ovf(a_out_ovf), .busy(a_busy));

    // Instance B: WIDTH=8, DIGITS=2 (overflow cases).
    logic b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
    logic b_out_sign, b_out_ovf, b_busy;
    logic [7:0] b_in_data = '0;
    logic [7:0] b_out_bcd;

    bcd_seq_conv #(.WIDTH(8), .DIGITS(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bcd(b_out_bcd),
        .out_sign(b_out_sign), .out_ovf(b_out_ovf), .busy(b_busy));

    // Instance C: WIDTH=16, DIGITS=5.
    logic c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1;
    logic c_out_sign, c_out_ovf, c_busy;
    logic [15:0] c_in_data = '0;
    logic [19:0] c_out_bcd;

    bcd_seq_conv #(.WIDTH(16), .DIGITS(5)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_bcd(c_out_bcd),
        .out_sign(c_out_sign), .out_ovf(c_out_ovf), .busy(c_busy));

    exp_t q_a[$], q_b[$], q_c[$];
    exp_t cur_a, cur_b, cur_c;
    int   stall_a = 0;
    int   a_wait = 0;
    logic a_seen = 1'b0;
    logic a_post = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model for the 16-bit sweep: decimal digits by repeated division.
    function automatic logic [19:0] to_bcd5(input int unsigned m);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic int unsigned c_mag(input logic [15:0] d);
`ifdef BCD_SIGNED_EN
        if (d[15]) return int'({16'd0, 16'(~d + 16'd1)});
`endif
        return int'({16'd0, d});
    endfunction

    function automatic logic c_sgn(input logic [15:0] d);
`ifdef BCD_SIGNED_EN
        return d[15];
`else
        return 1'b0;
`endif
    endfunction

    task automatic send_a(input logic [7:0] d, input logic [11:0] eb, input logic es, input logic eo);
        int guard = 0;
        @(negedge clk);
        while (!a_in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!a_in_ready) begin
            check("a_accept_timeout", 32'd0, 32'd1);
            return;
        end
        a_in_valid = 1'b1;
        a_in_data  = d;
        @(posedge clk);
        #1;
        q_a.push_back('{bcd: {8'd0, eb}, sign: es, ovf: eo, acc: cyc});
        a_in_valid = 1'b0;
        a_in_data  = ~d;
        check("a_busy_after_accept", {31'd0, a_busy}, 32'd1);
        check("a_in_ready_in_shift", {31'd0, a_in_ready}, 32'd0);
        check("a_bcd_zero_in_shift", {20'd0, a_out_bcd}, 32'd0);
    endtask

    task automatic send_b(input logic [7:0] d, input logic [7:0] eb, input logic es, input logic eo);
        int guard = 0;
        @(negedge clk);
        while (!b_in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!b_in_ready) begin
            check("b_accept_timeout", 32'd0, 32'd1);
            return;
        end
        b_in_valid = 1'b1;
        b_in_data  = d;
        @(posedge clk);
        #1;
        q_b.push_back('{bcd: {12'd0, eb}, sign: es, ovf: eo, acc: cyc});
        b_in_valid = 1'b0;
        b_in_data  = ~d;
    endtask

    task automatic send_c(input logic [15:0] d, input logic [19:0] eb, input logic es);
        int guard = 0;
        @(negedge clk);
        while (!c_in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!c_in_ready) begin
            check("c_accept_timeout", 32'd0, 32'd1);
            return;
        end
        c_in_valid = 1'b1;
        c_in_data  = d;
        @(posedge clk);
        #1;
        q_c.push_back('{bcd: eb, sign: es, ovf: 1'b0, acc: cyc});
        c_in_valid = 1'b0;
        c_in_data  = ~d;
    endtask

    // Monitor A: compares on first presentation, then holds out_ready low for stall_a cycles
    // while checking the result stays frozen.
    always @(negedge clk) begin
        if (rst) begin
            a_seen      = 1'b0;
            a_post      = 1'b0;
            a_out_ready = 1'b0;
        end else begin
            if (a_post) begin
                check("a_in_ready_after_hs", {31'd0, a_in_ready}, 32'd1);
                check("a_out_valid_after_hs", {31'd0, a_out_valid}, 32'd0);
                check("a_bcd_zero_after_hs", {20'd0, a_out_bcd}, 32'd0);
                a_post = 1'b0;
            end
            if (a_out_valid) begin
                if (!a_seen) begin
                    a_seen = 1'b1;
                    a_wait = 0;
                    if (q_a.size() == 0) begin
                        check("a_unexpected_output", 32'd1, 32'd0);
                    end else begin
                        cur_a  = q_a.pop_front();
                        a_wait = stall_a;
                        check("a_bcd", {20'd0, a_out_bcd}, {12'd0, cur_a.bcd});
                        check("a_sign", {31'd0, a_out_sign}, {31'd0, cur_a.sign});
                        check("a_ovf", {31'd0, a_out_ovf}, {31'd0, cur_a.ovf});
                        check("a_latency", 32'(cyc - cur_a.acc), 32'd8);
                    end
                end else begin
                    check("a_bcd_stable", {20'd0, a_out_bcd}, {12'd0, cur_a.bcd});
                    check("a_sign_stable", {31'd0, a_out_sign}, {31'd0, cur_a.sign});
                    check("a_ovf_stable", {31'd0, a_out_ovf}, {31'd0, cur_a.ovf});
                    check("a_in_ready_in_done", {31'd0, a_in_ready}, 32'd0);
                end
                if (a_wait == 0) begin
                    a_out_ready = 1'b1;
                    a_seen      = 1'b0;
                    a_post      = 1'b1;
                end else begin
                    a_out_ready = 1'b0;
                    a_wait--;
                end
            end else begin
                a_out_ready = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_output", 32'd1, 32'd0);
            end else begin
                cur_b = q_b.pop_front();
                check("b_bcd", {24'd0, b_out_bcd}, {12'd0, cur_b.bcd});
                check("b_sign", {31'd0, b_out_sign}, {31'd0, cur_b.sign});
                check("b_ovf", {31'd0, b_out_ovf}, {31'd0, cur_b.ovf});
                check("b_latency", 32'(cyc - cur_b.acc), 32'd8);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && c_out_valid) begin
            if (q_c.size() == 0) begin
                check("c_unexpected_output", 32'd1, 32'd0);
            end else begin
                cur_c = q_c.pop_front();
                check("c_bcd", {12'd0, c_out_bcd}, {12'd0, cur_c.bcd});
                check("c_sign", {31'd0, c_out_sign}, {31'd0, cur_c.sign});
                check("c_ovf", {31'd0, c_out_ovf}, 32'd0);
                check("c_latency", 32'(cyc - cur_c.acc), 32'd16);
            end
        end
    end

    task automatic drain();
        int guard = 0;
        while ((q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0 || a_out_valid) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("drain_q_a_empty", 32'(q_a.size()), 32'd0);
        check("drain_q_b_empty", 32'(q_b.size()), 32'd0);
        check("drain_q_c_empty", 32'(q_c.size()), 32'd0);
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_out_bcd", {20'd0, a_out_bcd}, 32'd0);
        check("rst_out_sign", {31'd0, a_out_sign}, 32'd0);
        check("rst_out_ovf", {31'd0, a_out_ovf}, 32'd0);
        check("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        rst = 1'b0;

`ifdef BCD_SIGNED_EN
        send_a(8'h80, 12'h128, 1'b1, 1'b0);
        send_a(8'hFF, 12'h001, 1'b1, 1'b0);
        send_a(8'h7F, 12'h127, 1'b0, 1'b0);
        send_a(8'h9C, 12'h100, 1'b1, 1'b0);
        send_a(8'h00, 12'h000, 1'b0, 1'b0);
`else
        send_a(8'd255, 12'h255, 1'b0, 1'b0);
        send_a(8'd0,   12'h000, 1'b0, 1'b0);
        send_a(8'd1,   12'h001, 1'b0, 1'b0);
        send_a(8'd100, 12'h100, 1'b0, 1'b0);
        send_a(8'd128, 12'h128, 1'b0, 1'b0);
        send_a(8'd9,   12'h009, 1'b0, 1'b0);
`endif
        drain();

        // Stalled consumer with in_valid pulses that must be ignored in DONE.
        stall_a = 5;
        send_a(8'd99, 12'h099, 1'b0, 1'b0);
        guard = 0;
        while (!a_out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("a_stall_out_valid_seen", {31'd0, a_out_valid}, 32'd1);
        a_in_data = 8'hAA;
        repeat (3) begin
            a_in_valid = 1'b1;
            @(negedge clk);
        end
        a_in_valid = 1'b0;
        drain();
        stall_a = 0;

        // Reset at SHIFT step 4 abandons the conversion.
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_data  = 8'h55;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, a_busy}, 32'd0);
        check("abort_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("abort_out_bcd", {20'd0, a_out_bcd}, 32'd0);
        check("abort_in_ready", {31'd0, a_in_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready_after_rst", {31'd0, a_in_ready}, 32'd1);
        check("abort_no_output", {31'd0, a_out_valid}, 32'd0);
        send_a(8'd42, 12'h042, 1'b0, 1'b0);
        drain();

`ifdef BCD_SIGNED_EN
        send_b(8'hC8, 8'h56, 1'b1, 1'b0);
        send_b(8'h63, 8'h99, 1'b0, 1'b0);
        send_b(8'h80, 8'h28, 1'b1, 1'b1);
        send_b(8'h9D, 8'h99, 1'b1, 1'b0);
        send_b(8'h64, 8'h00, 1'b0, 1'b1);
        send_c(16'hFFFF, 20'h00001, 1'b1);
        send_c(16'h8000, 20'h32768, 1'b1);
        send_c(16'h7FFF, 20'h32767, 1'b0);
        send_c(16'd12345, 20'h12345, 1'b0);
`else
        send_b(8'd200, 8'h00, 1'b0, 1'b1);
        send_b(8'd99,  8'h99, 1'b0, 1'b0);
        send_b(8'd255, 8'h55, 1'b0, 1'b1);
        send_b(8'd100, 8'h00, 1'b0, 1'b1);
        send_b(8'd10,  8'h10, 1'b0, 1'b0);
        send_c(16'd65535, 20'h65535, 1'b0);
        send_c(16'd0,     20'h00000, 1'b0);
        send_c(16'd12345, 20'h12345, 1'b0);
        send_c(16'd40000, 20'h40000, 1'b0);
`endif
        drain();

        for (int v = 7; v < 65536; v += 1021) begin
            send_c(16'(v), to_bcd5(c_mag(16'(v))), c_sgn(16'(v)));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
